// File: rtl/cnu_min_fold.sv
`default_nettype none
// ============================================================================
// Module   : cnu_min_fold
// Purpose  : Min-sum check-node back end. Folds 4-edge group results into a
//            global min1/min2/argmin/parity, then streams CN_DEGREE messages.
//            CNU_MIN_OFFSET_EN selects offset min-sum (sel-1, floored at 0).
// Revision : 1.0
// ============================================================================
module cnu_min_fold #(
    parameter int QUAN_SIZE = 3,
    parameter int CN_DEGREE = 10,
    parameter int IDX_W     = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QUAN_SIZE-1:0] in_m1,
    input  logic [QUAN_SIZE-1:0] in_m2,
    input  logic [1:0]           in_min_index,
    input  logic [3:0]           in_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QUAN_SIZE-1:0] out_mag,
    output logic                 out_sign,
    output logic [IDX_W-1:0]     out_edge,
    output logic                 out_last
);

    localparam int BEATS = (CN_DEGREE + 3) / 4;
    localparam int c_beat_w = (IDX_W > 2) ? IDX_W - 2 : 1;
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BEATS - 1);
    localparam logic [IDX_W-1:0]    c_last_edge = IDX_W'(CN_DEGREE - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_beat_w-1:0]    r_beat_cnt;
    logic [IDX_W-1:0]       r_edge_cnt;
    logic [QUAN_SIZE-1:0]   r_min1;
    logic [QUAN_SIZE-1:0]   r_min2;
    logic [IDX_W-1:0]       r_arg;
    logic                   r_parity;
    logic [CN_DEGREE-1:0]   r_edge_sign;
    logic                   r_out_valid;
    logic [QUAN_SIZE-1:0]   r_out_mag;
    logic                   r_out_sign;
    logic                   r_out_last;

    logic [3:0]             w_mask;
    logic [IDX_W-1:0]       w_arg_in;
    logic [QUAN_SIZE-1:0]   w_min1_nx;
    logic [QUAN_SIZE-1:0]   w_min2_nx;
    logic [IDX_W-1:0]       w_arg_nx;
    logic                   w_parity_nx;
    logic [CN_DEGREE-1:0]   w_edge_sign_nx;
    logic [(1<<IDX_W)-1:0]  w_sign_ext;
    logic [IDX_W-1:0]       w_edge_nx;
    logic [QUAN_SIZE-1:0]   w_sel_first;
    logic [QUAN_SIZE-1:0]   w_sel_nx;

    function automatic logic [QUAN_SIZE-1:0] f_mag(input logic [QUAN_SIZE-1:0] sel);
`ifdef CNU_MIN_OFFSET_EN
        f_mag = (sel == '0) ? sel : sel - QUAN_SIZE'(1);
`else
        f_mag = sel;
`endif
    endfunction

    // Fold of the current beat into the accumulators; padded edges are masked
    // out of the parity and never written to edge_sign.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < 4; k++) begin
            w_mask[k] = (int'(r_beat_cnt) * 4 + k) < CN_DEGREE;
        end
        w_arg_in    = IDX_W'({r_beat_cnt, in_min_index});
        w_min1_nx   = r_min1;
        w_min2_nx   = r_min2;
        w_arg_nx    = r_arg;
        w_parity_nx = r_parity ^ (^(in_sign & w_mask));
        if (r_beat_cnt == '0) begin
            w_min1_nx   = in_m1;
            w_min2_nx   = in_m2;
            w_arg_nx    = w_arg_in;
            w_parity_nx = ^(in_sign & w_mask);
        end else if (in_m1 < r_min1) begin
            w_min1_nx = in_m1;
            w_min2_nx = (r_min1 < in_m2) ? r_min1 : in_m2;
            w_arg_nx  = w_arg_in;
        end else begin
            w_min2_nx = (in_m1 < r_min2) ? in_m1 : r_min2;
        end

        w_edge_sign_nx = r_edge_sign;
        for (int e = 0; e < CN_DEGREE; e++) begin
            if ((e / 4) == int'(r_beat_cnt)) begin
                w_edge_sign_nx[e] = in_sign[e % 4];
            end
        end
    end

    always_comb begin
        w_sign_ext                = '0;
        w_sign_ext[CN_DEGREE-1:0] = r_edge_sign;
        w_edge_nx                 = r_edge_cnt + IDX_W'(1);
        w_sel_first               = (w_arg_nx == '0) ? w_min2_nx : w_min1_nx;
        w_sel_nx                  = (w_edge_nx == r_arg) ? r_min2 : r_min1;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_beat_cnt  <= '0;
            r_edge_cnt  <= '0;
            r_min1      <= '0;
            r_min2      <= '0;
            r_arg       <= '0;
            r_parity    <= 1'b0;
            r_edge_sign <= '0;
            r_out_valid <= 1'b0;
            r_out_mag   <= '0;
            r_out_sign  <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_min1      <= w_min1_nx;
                        r_min2      <= w_min2_nx;
                        r_arg       <= w_arg_nx;
                        r_parity    <= w_parity_nx;
                        r_edge_sign <= w_edge_sign_nx;
                        if (r_beat_cnt == c_last_beat) begin
                            // Edge 0 is built from the just-folded values.
                            r_state     <= ST_EMIT;
                            r_beat_cnt  <= '0;
                            r_edge_cnt  <= '0;
                            r_out_valid <= 1'b1;
                            r_out_mag   <= f_mag(w_sel_first);
                            r_out_sign  <= w_parity_nx ^ w_edge_sign_nx[0];
                            r_out_last  <= 1'b0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_beat_w'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (r_out_valid && out_ready) begin
                        if (r_edge_cnt == c_last_edge) begin
                            r_state     <= ST_ACCUM;
                            r_beat_cnt  <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_edge_cnt <= w_edge_nx;
                            r_out_mag  <= f_mag(w_sel_nx);
                            r_out_sign <= r_parity ^ w_sign_ext[w_edge_nx];
                            r_out_last <= (w_edge_nx == c_last_edge);
                        end
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = r_out_valid;
    assign out_mag   = r_out_mag;
    assign out_sign  = r_out_sign;
    assign out_edge  = r_edge_cnt;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_cnu_min_fold.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cnu_min_fold
// Purpose  : Self-checking bench for cnu_min_fold against an edge-level
//            min-sum reference model. Revision : 1.0
// ============================================================================
module tb_cnu_min_fold;

    localparam int Q  = 3;
    localparam int D  = 10;
    localparam int IW = 4;
    localparam int NB = (D + 3) / 4;
    localparam int NE = 4 * NB;

    typedef struct {
        logic [Q-1:0] m1;
        logic [Q-1:0] m2;
        logic [1:0]   idx;
        logic [3:0]   s;
    } beat_t;

    typedef struct {
        int   e;
        int   m;
        logic s;
        logic l;
    } msg_t;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [Q-1:0]  in_m1 = '0;
    logic [Q-1:0]  in_m2 = '0;
    logic [1:0]    in_min_index = '0;
    logic [3:0]    in_sign = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [Q-1:0]  out_mag;
    logic          out_sign;
    logic [IW-1:0] out_edge;
    logic          out_last;

    int    mag [NE];
    bit    sgn [NE];
    beat_t bq  [$];
    msg_t  exq [$];
    msg_t  gq  [$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;

    cnu_min_fold #(.QUAN_SIZE(Q), .CN_DEGREE(D), .IDX_W(IW)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_m1(in_m1), .in_m2(in_m2), .in_min_index(in_min_index), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mag(out_mag), .out_sign(out_sign), .out_edge(out_edge), .out_last(out_last)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic int off(input int x);
`ifdef CNU_MIN_OFFSET_EN
        return (x > 0) ? x - 1 : 0;
`else
        return x;
`endif
    endfunction

    // Case 0: directed, 1: tie across beats, 2: min1 of zero, other: random.
    task automatic load_case(input int t);
        int d0 [12] = '{6, 7, 5, 7, 7, 3, 7, 7, 4, 4, 7, 7};
        int d1 [12] = '{5, 2, 6, 7, 6, 7, 5, 2, 6, 7, 7, 7};
        int d2 [12] = '{3, 4, 0, 5, 6, 1, 7, 2, 5, 3, 7, 7};
        for (int e = 0; e < NE; e++) begin
            sgn[e] = bit'($urandom_range(0, 1));
            if (e >= D)       mag[e] = (1 << Q) - 1;
            else if (t == 0)  begin mag[e] = d0[e]; sgn[e] = (e == 0 || e == 9); end
            else if (t == 1)  mag[e] = d1[e];
            else if (t == 2)  mag[e] = d2[e];
            else              mag[e] = $urandom_range(0, (1 << Q) - 1);
        end
    endtask

    // Emulates the upstream 4-input merge stage.
    task automatic make_beats();
        for (int g = 0; g < NB; g++) begin
            beat_t b;
            int    lo;
            int    sec;
            lo = 0;
            for (int k = 1; k < 4; k++) if (mag[4*g+k] < mag[4*g+lo]) lo = k;
            sec = 1 << Q;
            for (int k = 0; k < 4; k++) if (k != lo && mag[4*g+k] < sec) sec = mag[4*g+k];
            b.m1  = Q'(mag[4*g+lo]);
            b.m2  = Q'(sec);
            b.idx = 2'(lo);
            for (int k = 0; k < 4; k++) b.s[k] = sgn[4*g+k];
            bq.push_back(b);
        end
    endtask

    task automatic build_model();
        int m1 = 1 << Q;
        int m2 = 1 << Q;
        int arg = 0;
        bit par = 1'b0;
        for (int e = 0; e < D; e++) begin
            if (mag[e] < m1) begin m1 = mag[e]; arg = e; end
            par ^= sgn[e];
        end
        for (int e = 0; e < D; e++) if (e != arg && mag[e] < m2) m2 = mag[e];
        for (int e = 0; e < D; e++) begin
            msg_t m;
            m.e = e;
            m.m = off((e == arg) ? m2 : m1);
            m.s = par ^ sgn[e];
            m.l = (e == D - 1);
            exq.push_back(m);
        end
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            int    w;
            w = 0;
            while (in_ready !== 1'b1 && w < 50) begin @(posedge sys_clk); #1; w++; end
            if (in_ready !== 1'b1) begin
                n_cmp++; n_err++;
                $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
            end
            b = bq.pop_front();
            in_m1 = b.m1; in_m2 = b.m2; in_min_index = b.idx; in_sign = b.s;
            in_valid = 1'b1;
            @(posedge sys_clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic recv(input int n);
        int w = 0;
        gq.delete();
        out_ready = 1'b1;
        while (gq.size() < n && w < 200) begin
            if (out_valid === 1'b1) begin
                msg_t m;
                m.e = int'(out_edge); m.m = int'(out_mag); m.s = out_sign; m.l = out_last;
                gq.push_back(m);
            end
            @(posedge sys_clk); #1;
            w++;
        end
        out_ready = 1'b0;
        if (gq.size() < n) begin
            n_cmp++; n_err++;
            $display("FAIL recv_timeout: got %0d messages required %0d", gq.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_mag, out_sign, out_edge, out_last} !== {1'b1, 1'b0, Q'(0), 1'b0, IW'(0), 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b vld=%b mag=%0d sgn=%b edge=%0d last=%b required 1 0 0 0 0 0",
                     in_ready, out_valid, out_mag, out_sign, out_edge, out_last);
        end
        rst = 1'b0;
        @(posedge sys_clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_patterns();
        for (int t = 0; t < 12; t++) begin
            bq.delete(); exq.delete();
            load_case(t); make_beats(); build_model();
            send_beats(NB);
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL first_latency case %0d: out_valid=%b required 1", t, out_valid);
            end
            recv(D);
            while (exq.size() > 0) begin
                msg_t x;
                msg_t g;
                x = exq.pop_front();
                n_cmp++;
                if (gq.size() == 0) begin
                    n_err++;
                    $display("FAIL msg_missing case %0d edge %0d", t, x.e);
                end else begin
                    g = gq.pop_front();
                    if (g.e !== x.e || g.m !== x.m || g.s !== x.s || g.l !== x.l) begin
                        n_err++;
                        $display("FAIL msg case %0d: edge=%0d mag=%0d sign=%b last=%b required edge=%0d mag=%0d sign=%b last=%b",
                                 t, g.e, g.m, g.s, g.l, x.e, x.m, x.s, x.l);
                    end
                end
            end
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL return_accum case %0d: rdy=%b vld=%b required 1 0", t, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int w = 0;
        bq.delete(); exq.delete();
        load_case(99); make_beats(); build_model();
        send_beats(NB);
        out_ready = 1'b1;
        @(posedge sys_clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge sys_clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, out_edge, out_mag, out_sign, out_last} !==
                {1'b1, 1'b0, IW'(1), Q'(exq[1].m), exq[1].s, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold %0d: vld=%b rdy=%b edge=%0d mag=%0d sign=%b required 1 0 1 %0d %b",
                         i, out_valid, in_ready, out_edge, out_mag, out_sign, exq[1].m, exq[1].s);
            end
        end
        out_ready = 1'b1;
        @(posedge sys_clk); #1;
        n_cmp++;
        if (out_edge !== IW'(2)) begin
            n_err++;
            $display("FAIL stall_progress: edge=%0d required 2", out_edge);
        end
        while (out_valid === 1'b1 && w < 50) begin
            if (out_edge === IW'(D - 1)) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL ready_in_emit: in_ready=%b required 0", in_ready);
                end
            end
            @(posedge sys_clk); #1;
            w++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_end: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bq.delete(); exq.delete();
        load_case(99); make_beats();
        send_beats(2);
        bq.delete();
        rst = 1'b1;
        @(posedge sys_clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_accum: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
        rst = 1'b0;
        load_case(99); make_beats();
        send_beats(NB);
        out_ready = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_edge !== IW'(4)) begin
            n_err++;
            $display("FAIL pre_reset_edge: edge=%0d required 4", out_edge);
        end
        rst = 1'b1;
        @(posedge sys_clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_emit: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
        rst = 1'b0;
        load_case(99); make_beats(); build_model();
        send_beats(NB);
        recv(D);
        while (exq.size() > 0) begin
            msg_t x;
            msg_t g;
            x = exq.pop_front();
            n_cmp++;
            if (gq.size() == 0) begin
                n_err++;
                $display("FAIL fresh_missing edge %0d", x.e);
            end else begin
                g = gq.pop_front();
                if (g.e !== x.e || g.m !== x.m || g.s !== x.s || g.l !== x.l) begin
                    n_err++;
                    $display("FAIL fresh_msg: edge=%0d mag=%0d sign=%b last=%b required edge=%0d mag=%0d sign=%b last=%b",
                             g.e, g.m, g.s, g.l, x.e, x.m, x.s, x.l);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int    first [$];
        int    w = 0;
        bit    took;
        beat_t b;
        bq.delete(); exq.delete(); gq.delete();
        for (int c = 0; c < 2; c++) begin
            load_case(99); make_beats(); build_model();
        end
        out_ready = 1'b1;
        while (gq.size() < 2 * D && w < 100) begin
            took = 1'b0;
            if (bq.size() > 0) begin
                in_m1 = bq[0].m1; in_m2 = bq[0].m2; in_min_index = bq[0].idx; in_sign = bq[0].s;
                in_valid = 1'b1;
                took = (in_ready === 1'b1);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                msg_t m;
                m.e = int'(out_edge); m.m = int'(out_mag); m.s = out_sign; m.l = out_last;
                gq.push_back(m);
                if (out_edge === '0) first.push_back(cyc);
            end
            @(posedge sys_clk); #1;
            w++;
            if (took) b = bq.pop_front();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (first.size() != 2) begin
            n_err++;
            $display("FAIL b2b_first_count: got %0d required 2", first.size());
        end else if (first[1] - first[0] != NB + D) begin
            n_err++;
            $display("FAIL b2b_period: got %0d cycles required %0d", first[1] - first[0], NB + D);
        end
        while (exq.size() > 0) begin
            msg_t x;
            msg_t g;
            x = exq.pop_front();
            n_cmp++;
            if (gq.size() == 0) begin
                n_err++;
                $display("FAIL b2b_missing edge %0d", x.e);
            end else begin
                g = gq.pop_front();
                if (g.e !== x.e || g.m !== x.m || g.s !== x.s || g.l !== x.l) begin
                    n_err++;
                    $display("FAIL b2b_msg: edge=%0d mag=%0d sign=%b last=%b required edge=%0d mag=%0d sign=%b last=%b",
                             g.e, g.m, g.s, g.l, x.e, x.m, x.s, x.l);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cnu_min_fold.md
# cnu_min_fold

Sequential check-node back end for the layered min-sum decoder. It consumes the per-group results of the 4-input merge stage (the group minimum, the group second minimum and the in-group argmin for four edges per beat), together with the four edge signs. Over ceil(CN_DEGREE/4) beats it folds these into a global min1, min2, argmin and sign parity. It then streams CN_DEGREE check-to-variable messages, one edge per handshake.

## Interface
- QUAN_SIZE, 3: magnitude width in bits.
- CN_DEGREE, 10: check-node degree; valid range 2..16.
- IDX_W, 4: edge index width; must satisfy 2^IDX_W >= 4*BEATS.
- BEATS (localparam): ceil(CN_DEGREE/4); equals 3 at the default degree.
- sys_clk  in  1  the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a group beat is present.
- in_ready  out  1  the block accepts a beat.
- in_m1  in  QUAN_SIZE  group minimum magnitude.
- in_m2  in  QUAN_SIZE  group second-minimum magnitude.
- in_min_index  in  2  in-group position of in_m1.
- in_sign  in  4  signs of the four group edges; bit k is edge 4*beat+k.
- out_valid  out  1  a message is present.
- out_ready  in  1  the consumer accepts the message.
- out_mag  out  QUAN_SIZE  message magnitude.
- out_sign  out  1  message sign.
- out_edge  out  IDX_W  edge number, 0..CN_DEGREE-1.
- out_last  out  1  high with edge CN_DEGREE-1.

## Operation
- Two states: ACCUM and EMIT. Reset enters ACCUM.
- ACCUM: in_ready=1 and out_valid=0. beat_cnt counts accepted beats, 0..BEATS-1.
- Beat 0 loads the accumulators: min1=in_m1, min2=in_m2, arg={beat,in_min_index}, parity=XOR of the valid sign bits.
- Beat b>0, when in_m1 < min1 (strict): min1=in_m1, min2=min(min1,in_m2), arg=4*b+in_min_index.
- Beat b>0, otherwise: min2=min(min2,in_m1), and min1 and arg are unchanged.
- Ties keep the earlier beat.
- Sign bits for edges >= CN_DEGREE are ignored. Upstream pads the magnitudes of those edges with all-ones.
- The sign bits of edges < CN_DEGREE are stored in an edge_sign[CN_DEGREE-1:0] register.
- Acceptance of beat BEATS-1 moves the block to EMIT with edge_cnt=0.
- EMIT, per edge e:
  - out_mag = (e==arg) ? min2 : min1.
  - out_sign = parity ^ edge_sign[e].
  - out_edge = e.
- edge_cnt advances only on out_valid && out_ready.
- Handshake on edge CN_DEGREE-1 returns the block to ACCUM and clears beat_cnt.
- All magnitude comparisons are unsigned. No arithmetic widens beyond QUAN_SIZE.

## Timing
- Reset values: in_ready=1 (state ACCUM), out_valid=0, out_mag=0, out_sign=0, out_edge=0, out_last=0. All accumulators, counters and edge_sign are 0.
- rst has priority in every state. Asserting it mid-ACCUM or mid-EMIT discards partial data. The block is in ACCUM on the cycle after rst is released.
- Output registers are loaded on the ACCUM->EMIT edge and on each EMIT handshake.
- First message: last beat accepted at edge t gives out_valid=1 after edge t. Latency is 1 cycle.
- While out_ready is held low, out_* hold stable and out_valid stays 1.
- in_ready=0 throughout EMIT. There is no overlap between check nodes.
- Last EMIT handshake at edge t gives in_ready=1 after t.
- Throughput with continuous valid/ready: BEATS+CN_DEGREE cycles per check node (13 at the defaults).

## Configuration
- CNU_MIN_OFFSET_EN defined: offset min-sum. out_mag = max(sel-1, 0), where sel is min1 or min2 as selected. A selected value of 0 stays 0. Output latency is unchanged.
- CNU_MIN_OFFSET_EN undefined: plain min-sum. out_mag = sel.

## Test plan
All cases use the defaults and plain min-sum unless stated.
- Beats (m1,m2,idx,sign) = (5,6,2,0001), (3,7,1,0000), (4,4,0,0010), with edges 10/11 padded to 7:
  - required: min1=3, min2=4, arg=5, parity=0.
  - required: edge 5 gives mag 4; every other edge gives mag 3; edge 0 and edge 9 have sign 1.
  - out_last is high only with edge 9.
- Tie: beats with in_m1=2 in beat 0 (idx 1) and beat 1 (idx 3) -> arg=1, min2=2, so every edge gives mag 2.
- Backpressure: out_ready toggles 1,0,0,1 over 4 cycles -> only 2 edges complete, and outputs are stable while stalled. in_ready stays 0 until edge 9 handshakes.
- Reset after beat 1 and mid-EMIT at edge 4 -> the next cycle shows in_ready=1, out_valid=0. A fresh codeword then decodes correctly.
- CNU_MIN_OFFSET_EN defined, first case repeated -> edge 5 gives mag 3 and the others mag 2. A case with min1=0 gives mag 0 and does not wrap.
- Back-to-back codewords with continuous valid/ready -> exactly 13 cycles between successive first messages.
